// File: rtl/scoreboard_ctrl.sv
// Register scoreboard for the dual-issue pipe: one pending bit per architectural register.
// Define SB_CHECK_EN to build the sticky waw_err/wb_err debug checkers; otherwise both are tied 0.
//
// state   | meaning
// S_IDLE  | no outstanding producer, bit low
// S_TIMED | fixed-latency producer, counter running down to 1
// S_WAIT  | variable-latency producer, waiting for a writeback
module scoreboard_ctrl #(
    parameter int NUM_REGS = 32,
    parameter int LAT_W    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                iss_a_valid,
    input  logic [4:0]          iss_a_rd,
    input  logic [LAT_W-1:0]    iss_a_lat,
    input  logic                iss_b_valid,
    input  logic [4:0]          iss_b_rd,
    input  logic [LAT_W-1:0]    iss_b_lat,
    input  logic                wb_a_valid,
    input  logic [4:0]          wb_a_rd,
    input  logic                wb_b_valid,
    input  logic [4:0]          wb_b_rd,
    output logic [NUM_REGS-1:0] scoreboard,
    output logic [5:0]          pending_cnt,
    output logic                waw_err,
    output logic                wb_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TIMED = 2'd1,
        S_WAIT  = 2'd2
    } ent_state_t;

    ent_state_t       state_q [NUM_REGS];
    ent_state_t       state_d [NUM_REGS];
    logic [LAT_W-1:0] cnt_q   [NUM_REGS];
    logic [LAT_W-1:0] cnt_d   [NUM_REGS];

    logic [NUM_REGS-1:0] hit_iss_a, hit_iss_b, hit_wb;
    logic [NUM_REGS-1:0] clearing;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            hit_iss_a[i] = iss_a_valid && (iss_a_rd == 5'(i)) && (i != 0);
            hit_iss_b[i] = iss_b_valid && (iss_b_rd == 5'(i)) && (i != 0);
            hit_wb[i]    = ((wb_a_valid && (wb_a_rd == 5'(i))) ||
                            (wb_b_valid && (wb_b_rd == 5'(i)))) && (i != 0);
            // entry would drop to idle this edge on its own (wb or final count)
            clearing[i]  = (state_q[i] == S_WAIT && hit_wb[i]) ||
                           (state_q[i] == S_TIMED && cnt_q[i] == LAT_W'(1));
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (i == 0 || flush) begin
                state_d[i] = S_IDLE;
                cnt_d[i]   = '0;
            end else if (hit_iss_b[i]) begin
                state_d[i] = (iss_b_lat == '0) ? S_WAIT : S_TIMED;
                cnt_d[i]   = iss_b_lat;
            end else if (hit_iss_a[i]) begin
                state_d[i] = (iss_a_lat == '0) ? S_WAIT : S_TIMED;
                cnt_d[i]   = iss_a_lat;
            end else if (state_q[i] == S_WAIT && hit_wb[i]) begin
                state_d[i] = S_IDLE;
                cnt_d[i]   = '0;
            end else if (state_q[i] == S_TIMED) begin
                if (cnt_q[i] == LAT_W'(1)) begin
                    state_d[i] = S_IDLE;
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] - LAT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end else begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        pending_cnt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            scoreboard[i] = (state_q[i] != S_IDLE);
            pending_cnt   = pending_cnt + 6'(scoreboard[i]);
        end
    end

`ifdef SB_CHECK_EN
    logic waw_q, wb_q;
    logic waw_set, wb_set;

    // A/B pairs to the same rd are judged only against the registered state.
    always_comb begin
        waw_set = 1'b0;
        wb_set  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if ((hit_iss_a[i] || hit_iss_b[i]) && !flush &&
                state_q[i] != S_IDLE && !clearing[i])
                waw_set = 1'b1;
            if (hit_wb[i] && state_q[i] != S_WAIT)
                wb_set = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            waw_q <= 1'b0;
            wb_q  <= 1'b0;
        end else begin
            waw_q <= waw_q | waw_set;
            wb_q  <= wb_q | wb_set;
        end
    end

    assign waw_err = waw_q;
    assign wb_err  = wb_q;
`else
    assign waw_err = 1'b0;
    assign wb_err  = 1'b0;
`endif

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Directed bench for scoreboard_ctrl; error-flag expectations follow whether SB_CHECK_EN is defined.
module tb_scoreboard_ctrl;

`ifdef SB_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        iss_a_valid, iss_b_valid, wb_a_valid, wb_b_valid;
    logic [4:0]  iss_a_rd, iss_b_rd, wb_a_rd, wb_b_rd;
    logic [2:0]  iss_a_lat, iss_b_lat;
    logic [31:0] scoreboard;
    logic [5:0]  pending_cnt;
    logic        waw_err, wb_err;

    int checks = 0;
    int errors = 0;

    scoreboard_ctrl #(.NUM_REGS(32), .LAT_W(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .iss_a_valid(iss_a_valid), .iss_a_rd(iss_a_rd), .iss_a_lat(iss_a_lat),
        .iss_b_valid(iss_b_valid), .iss_b_rd(iss_b_rd), .iss_b_lat(iss_b_lat),
        .wb_a_valid(wb_a_valid), .wb_a_rd(wb_a_rd),
        .wb_b_valid(wb_b_valid), .wb_b_rd(wb_b_rd),
        .scoreboard(scoreboard), .pending_cnt(pending_cnt),
        .waw_err(waw_err), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; flush = 1'b0;
        iss_a_valid = 1'b0; iss_a_rd = '0; iss_a_lat = '0;
        iss_b_valid = 1'b0; iss_b_rd = '0; iss_b_lat = '0;
        wb_a_valid = 1'b0; wb_a_rd = '0;
        wb_b_valid = 1'b0; wb_b_rd = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] exp_sb, input logic [5:0] exp_cnt,
                           input logic exp_waw, input logic exp_wb);
        chk({tag, ".sb"}, scoreboard, exp_sb);
        chk({tag, ".cnt"}, {26'd0, pending_cnt}, {26'd0, exp_cnt});
        chk({tag, ".waw"}, {31'd0, waw_err}, {31'd0, exp_waw});
        chk({tag, ".wb"}, {31'd0, wb_err}, {31'd0, exp_wb});
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        chk_all("reset", 32'h0, 6'd0, 1'b0, 1'b0);

        // fixed latency 3 on rd 5
        iss_a_valid = 1'b1; iss_a_rd = 5'd5; iss_a_lat = 3'd3;
        cycle();
        idle_inputs();
        chk_all("lat3_c1", 32'h20, 6'd1, 1'b0, 1'b0);
        cycle();
        chk("lat3_c2", scoreboard, 32'h20);
        cycle();
        chk("lat3_c3", scoreboard, 32'h20);
        cycle();
        chk_all("lat3_done", 32'h0, 6'd0, 1'b0, 1'b0);

        // variable latency on rd 7 via pipe B
        iss_b_valid = 1'b1; iss_b_rd = 5'd7; iss_b_lat = 3'd0;
        cycle();
        idle_inputs();
        for (int k = 0; k < 9; k++) cycle();
        chk_all("wait7_hold", 32'h80, 6'd1, 1'b0, 1'b0);
        wb_a_valid = 1'b1; wb_a_rd = 5'd7;
        cycle();
        idle_inputs();
        chk_all("wait7_wb", 32'h0, 6'd0, 1'b0, 1'b0);

        // same-cycle A/B to rd 9: B (lat 0) wins
        iss_a_valid = 1'b1; iss_a_rd = 5'd9; iss_a_lat = 3'd1;
        iss_b_valid = 1'b1; iss_b_rd = 5'd9; iss_b_lat = 3'd0;
        cycle();
        idle_inputs();
        for (int k = 0; k < 5; k++) cycle();
        chk_all("ab_same_rd", 32'h200, 6'd1, 1'b0, 1'b0);
        wb_b_valid = 1'b1; wb_b_rd = 5'd9;
        cycle();
        idle_inputs();
        chk_all("ab_wb", 32'h0, 6'd0, 1'b0, 1'b0);

        // issue and writeback collide on rd 4
        iss_a_valid = 1'b1; iss_a_rd = 5'd4; iss_a_lat = 3'd0;
        cycle();
        idle_inputs();
        chk("wait4", scoreboard, 32'h10);
        wb_a_valid = 1'b1; wb_a_rd = 5'd4;
        iss_a_valid = 1'b1; iss_a_rd = 5'd4; iss_a_lat = 3'd2;
        cycle();
        idle_inputs();
        chk_all("coll_c1", 32'h10, 6'd1, 1'b0, 1'b0);
        cycle();
        chk("coll_c2", scoreboard, 32'h10);
        cycle();
        chk_all("coll_done", 32'h0, 6'd0, 1'b0, 1'b0);

        // dual writeback to the same rd
        iss_a_valid = 1'b1; iss_a_rd = 5'd11; iss_a_lat = 3'd0;
        cycle();
        idle_inputs();
        wb_a_valid = 1'b1; wb_a_rd = 5'd11;
        wb_b_valid = 1'b1; wb_b_rd = 5'd11;
        cycle();
        idle_inputs();
        chk_all("dual_wb", 32'h0, 6'd0, 1'b0, 1'b0);

        // rd 0 is never tracked
        iss_a_valid = 1'b1; iss_a_rd = 5'd0; iss_a_lat = 3'd0;
        iss_b_valid = 1'b1; iss_b_rd = 5'd0; iss_b_lat = 3'd5;
        cycle();
        idle_inputs();
        chk_all("rd0", 32'h0, 6'd0, 1'b0, 1'b0);

        // flush discards everything including same-cycle issue
        iss_a_valid = 1'b1; iss_a_rd = 5'd1; iss_a_lat = 3'd0;
        iss_b_valid = 1'b1; iss_b_rd = 5'd2; iss_b_lat = 3'd4;
        cycle();
        idle_inputs();
        iss_a_valid = 1'b1; iss_a_rd = 5'd3; iss_a_lat = 3'd7;
        cycle();
        idle_inputs();
        chk_all("pre_flush", 32'h0000_000E, 6'd3, 1'b0, 1'b0);
        flush = 1'b1;
        iss_a_valid = 1'b1; iss_a_rd = 5'd8; iss_a_lat = 3'd2;
        cycle();
        idle_inputs();
        chk_all("flush", 32'h0, 6'd0, 1'b0, 1'b0);
        cycle();
        chk("flush_after", scoreboard, 32'h0);

        // reset mid-countdown leaves nothing behind
        iss_a_valid = 1'b1; iss_a_rd = 5'd10; iss_a_lat = 3'd7;
        cycle();
        idle_inputs();
        cycle();
        chk("mid_cnt", scoreboard, 32'h400);
        rst = 1'b1;
        cycle();
        idle_inputs();
        chk_all("rst_mid", 32'h0, 6'd0, 1'b0, 1'b0);
        cycle();
        chk("rst_resid", scoreboard, 32'h0);

        // WAW overwrite: WAIT replaced by a 2-cycle TIMED producer
        iss_b_valid = 1'b1; iss_b_rd = 5'd13; iss_b_lat = 3'd0;
        cycle();
        idle_inputs();
        iss_a_valid = 1'b1; iss_a_rd = 5'd13; iss_a_lat = 3'd2;
        cycle();
        idle_inputs();
        chk_all("waw_c1", 32'h2000, 6'd1, CHK, 1'b0);
        cycle();
        chk("waw_c2", scoreboard, 32'h2000);
        cycle();
        chk("waw_done", scoreboard, 32'h0);
        rst = 1'b1;
        cycle();
        idle_inputs();

        // sticky debug flags
        iss_a_valid = 1'b1; iss_a_rd = 5'd6; iss_a_lat = 3'd0;
        cycle();
        idle_inputs();
        chk_all("waw_first", 32'h40, 6'd1, 1'b0, 1'b0);
        iss_b_valid = 1'b1; iss_b_rd = 5'd6; iss_b_lat = 3'd0;
        cycle();
        idle_inputs();
        chk_all("waw_second", 32'h40, 6'd1, CHK, 1'b0);
        wb_a_valid = 1'b1; wb_a_rd = 5'd12;
        cycle();
        idle_inputs();
        chk_all("wb_idle", 32'h40, 6'd1, CHK, CHK);
        flush = 1'b1;
        cycle();
        idle_inputs();
        chk_all("flag_flush", 32'h0, 6'd0, CHK, CHK);
        rst = 1'b1;
        cycle();
        idle_inputs();
        chk_all("flag_rst", 32'h0, 6'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scoreboard_ctrl.md
Name: scoreboard_ctrl

Overview:
- Sequential owner of the 32-entry register scoreboard that the dual-issue hazard logic reads every cycle.
- Sets a pending bit when pipe A or pipe B issues a register-writing instruction.
- Clears the bit after a fixed countdown for fixed-latency ops, or on an explicit writeback for variable-latency ops (loads).
- Handles same-cycle issue/writeback collisions, pipeline flush and debug error flags.

Parameters:
- NUM_REGS, 32, number of architectural registers tracked; entry 0 is hardwired idle.
- LAT_W, 3, width of per-entry latency countdown; maximum fixed latency is 2^LAT_W-1.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  clear all pending state (mispredict/trap)
- iss_a_valid  in  1  pipe A issues an instruction with reg_write and rd!=0 this cycle
- iss_a_rd  in  5  destination of pipe A issue
- iss_a_lat  in  LAT_W  fixed latency in cycles; 0 = variable, wait for writeback
- iss_b_valid  in  1  pipe B issue (B is younger than A in the same cycle)
- iss_b_rd  in  5  destination of pipe B issue
- iss_b_lat  in  LAT_W  as iss_a_lat
- wb_a_valid  in  1  variable-latency writeback on port A
- wb_a_rd  in  5  register written back
- wb_b_valid  in  1  variable-latency writeback on port B
- wb_b_rd  in  5  register written back
- scoreboard  out  NUM_REGS  pending bit per register, registered; bit 0 always 0
- pending_cnt  out  6  popcount of scoreboard (combinational from registered state)
- waw_err  out  1  sticky: issue to an already-pending rd (SB_CHECK_EN only)
- wb_err  out  1  sticky: writeback to an idle or timed entry (SB_CHECK_EN only)

Behaviour:
- Per-entry state machine: IDLE, TIMED (counter running), WAIT (awaiting writeback). scoreboard[i] = (state != IDLE).
- Reset (rst=1): all entries IDLE, counters 0, scoreboard=0, pending_cnt=0, waw_err=0, wb_err=0.
- Issue at edge t with lat=L>0: entry goes TIMED with cnt=L. Bit is high in cycles t+1..t+L, low from t+L+1.
  - Each cycle in TIMED: if cnt==1, go IDLE; else cnt-=1.
- Issue with lat=0: entry goes WAIT. It stays there until a wb_x_valid names it, then goes IDLE next edge (bit low the cycle after the wb cycle).
- Any input naming rd=0 is ignored.
- Priority per entry, highest first:
  1. rst
  2. flush
  3. issue B
  4. issue A
  5. writeback
  6. countdown
- Consequences of that priority:
  - Issue and writeback to the same rd in one cycle: the issue wins and the new producer's state is loaded. The writeback belongs to the older producer.
  - iss_a and iss_b to the same rd in one cycle: B's latency and state are loaded (younger producer).
  - Issue to an entry already TIMED or WAIT: overwritten with the new state and counter (WAW, youngest producer owns the bit).
- wb_a and wb_b to the same rd in one cycle: entry goes IDLE once.
- Writeback to an IDLE or TIMED entry: no state change.
- Flush: all entries IDLE at the next edge; same-cycle issues are discarded. Sticky error flags are NOT cleared by flush, only by rst.
- Reset asserted mid-countdown: entries go IDLE immediately at that edge, with no residual counts.
- No combinational path from inputs to scoreboard; one-cycle update latency.

Optional Feature:
- Macro SB_CHECK_EN.
- Defined:
  - waw_err sets on any issue whose rd is already non-IDLE and is not simultaneously cleared.
  - wb_err sets on a writeback to an entry that is not WAIT.
  - Same-cycle A/B issue to the same rd does NOT set waw_err.
  - Both flags are sticky until rst.
- Undefined: waw_err and wb_err tied 0, and no checking logic is synthesised.

Test Plan:
- Reset, then iss_a rd=5 lat=3 -> scoreboard[5]=1 for exactly 3 cycles, then 0; pending_cnt 1 then 0.
- iss_b rd=7 lat=0 -> scoreboard[7]=1 indefinitely; wb_a rd=7 at cycle 10 -> bit 0 from cycle 11.
- Same cycle: iss_a rd=9 lat=1 and iss_b rd=9 lat=0 -> entry 9 in WAIT, still high after 5 cycles, no waw_err.
- Pending WAIT on rd=4; same cycle wb_a rd=4 and iss_a rd=4 lat=2 -> bit stays high 2 more cycles then clears; waw_err=0 (cleared same cycle).
- Issues to rd=1,2,3 (lat 0,4,7), flush at next cycle with iss_a rd=8 -> scoreboard=0 and pending_cnt=0 the cycle after; rd=8 not set.
- SB_CHECK_EN: iss rd=6 lat=0 twice in different cycles -> waw_err=1; wb rd=12 while idle -> wb_err=1; flags persist through flush and clear only on rst.
